// File: rtl/ysyx_23060201_mem_arbiter_pkg.sv
// Shared types for the IFU/LSU data-memory arbiter: FSM states and grant identifiers.
package ysyx_23060201_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam logic GNT_IFU = 1'b0;
    localparam logic GNT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_23060201_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a contended pick goes to the
// requester that did not win last time.
module ysyx_23060201_rr_arb2
    import ysyx_23060201_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_id,
    output logic       gnt_vld
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        gnt_vld = |req;
        gnt_id  = GNT_IFU;
        if (req == 2'b11) begin
            gnt_id = ~last;
        end else if (req[GNT_LSU]) begin
            gnt_id = GNT_LSU;
        end
    end

endmodule

// File: rtl/ysyx_23060201_mem_arbiter.sv
// Serialises IFU fetches and LSU loads/stores onto the single MEM port, one
// transaction in flight, round-robin under contention.
module ysyx_23060201_mem_arbiter
    import ysyx_23060201_mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MASK_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_req_addr,
    output logic                  ifu_resp_valid,
    input  logic                  ifu_resp_ready,
    output logic [DATA_WIDTH-1:0] ifu_resp_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic                  lsu_req_wen,
    input  logic [ADDR_WIDTH-1:0] lsu_req_addr,
    input  logic [DATA_WIDTH-1:0] lsu_req_wdata,
    input  logic [MASK_WIDTH-1:0] lsu_req_wmask,
    output logic                  lsu_resp_valid,
    input  logic                  lsu_resp_ready,
    output logic [DATA_WIDTH-1:0] lsu_resp_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    output logic [MASK_WIDTH-1:0] mem_req_wmask,
    input  logic                  mem_resp_valid,
    output logic                  mem_resp_ready,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  grant;
    logic                  last_grant;
    logic                  pick_id;
    logic                  pick_vld;
    logic                  accept;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] wmask_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    ysyx_23060201_rr_arb2 u_rr_arb2 (
        .req     ({lsu_req_valid, ifu_req_valid}),
        .last    (last_grant),
        .gnt_id  (pick_id),
        .gnt_vld (pick_vld)
    );

    // Gated by rst_n so no request looks accepted while the block is held in reset.
    assign accept = rst_n && (state == ARB_IDLE) && pick_vld;

    // NOTE: sequential state uses <= so every register updates from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB_IDLE:  if (pick_vld)       state_next = ARB_ISSUE;
            ARB_ISSUE: if (mem_req_ready)  state_next = ARB_WAIT;
            ARB_WAIT:  if (mem_resp_valid) state_next = ARB_RESP;
            ARB_RESP:  if ((grant == GNT_IFU) ? ifu_resp_ready : lsu_resp_ready)
                           state_next = ARB_IDLE;
            default:   state_next = ARB_IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready  = 1'b0;
        lsu_req_ready  = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        ifu_resp_valid = 1'b0;
        lsu_resp_valid = 1'b0;
        case (state)
            ARB_IDLE: begin
                ifu_req_ready = accept && (pick_id == GNT_IFU);
                lsu_req_ready = accept && (pick_id == GNT_LSU);
            end
            ARB_ISSUE: mem_req_valid  = 1'b1;
            ARB_WAIT:  mem_resp_ready = 1'b1;
            ARB_RESP: begin
                ifu_resp_valid = (grant == GNT_IFU);
                lsu_resp_valid = (grant == GNT_LSU);
            end
            default: ;
        endcase
    end

    // Request fields are frozen at accept so MEM sees them stable through any stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= GNT_IFU;
            last_grant <= GNT_IFU;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                grant      <= pick_id;
                last_grant <= pick_id;
                if (pick_id == GNT_IFU) begin
                    wen_q   <= 1'b0;
                    addr_q  <= ifu_req_addr;
                    wdata_q <= '0;
                    wmask_q <= '0;
                end else begin
                    wen_q   <= lsu_req_wen;
                    addr_q  <= lsu_req_addr;
                    wdata_q <= lsu_req_wdata;
                    wmask_q <= lsu_req_wen ? lsu_req_wmask : '0;
                end
            end
            if ((state == ARB_WAIT) && mem_resp_valid) begin
                rdata_q <= wen_q ? '0 : mem_resp_rdata;
            end
        end
    end

    assign mem_req_wen    = wen_q;
    assign mem_req_addr   = addr_q;
    assign mem_req_wdata  = wdata_q;
    assign mem_req_wmask  = wmask_q;
    assign ifu_resp_rdata = rdata_q;
    assign lsu_resp_rdata = rdata_q;

endmodule

// File: tb/tb_ysyx_23060201_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: bench-side IFU, LSU and MEM agents driven
// cycle by cycle, checked against a transaction-level model with a word-array memory.
module tb_ysyx_23060201_mem_arbiter;
    import ysyx_23060201_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
    logic [31:0] ifu_req_addr, ifu_resp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_resp_valid, lsu_resp_ready;
    logic [31:0] lsu_req_addr, lsu_req_wdata, lsu_resp_rdata;
    logic [7:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, mem_resp_ready;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    logic [7:0]  mem_req_wmask;

    always #5 clk = ~clk;

    ysyx_23060201_mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_req_addr   (ifu_req_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .ifu_resp_rdata (ifu_resp_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_addr   (lsu_req_addr),
        .lsu_req_wdata  (lsu_req_wdata),
        .lsu_req_wmask  (lsu_req_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .lsu_resp_rdata (lsu_resp_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_wen    (mem_req_wen),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_ready (mem_resp_ready),
        .mem_resp_rdata (mem_resp_rdata)
    );

    // A requester must keep valid high until it is accepted.
    a_ifu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (ifu_req_valid && !ifu_req_ready) |=> ifu_req_valid);
    a_lsu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (lsu_req_valid && !lsu_req_ready) |=> lsu_req_valid);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference memory: 16 words starting at 0x80000000.
    logic [31:0] mem_arr [16];

    // Transaction-level model of the arbiter.
    bit          ifu_want, lsu_want;
    bit          busy, owner, last_model, mreq_done, mresp_done;
    logic        txn_wen;
    logic [31:0] txn_addr, txn_wdata, exp_rdata;
    logic [7:0]  txn_wmask;
    bit          glog [$];

    // MEM agent.
    bit          mem_busy;
    int          mem_cnt, ready_hold, rr_hold;
    logic        mreq_wen;
    logic [31:0] mreq_addr, mreq_wdata;
    logic [7:0]  mreq_wmask;

    // Knobs and measurements.
    int ifu_rate, lsu_rate, stall_lo, stall_hi, delay_lo, delay_hi, rrh_lo, rrh_hi;
    int cyc, accept_cyc, last_latency, n_mem_resp, n_resp_hs, n_resp_vld;
    bit lat_seen;
    logic [31:0] last_ifu_rdata, last_lsu_rdata;

    function automatic int urand(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h8000_0000 + (32'($urandom_range(15)) << 2);
    endfunction

    task automatic post_ifu(input logic [31:0] addr);
        ifu_want     = 1'b1;
        ifu_req_addr = addr;
    endtask

    task automatic post_lsu(input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [7:0] wmask);
        lsu_want      = 1'b1;
        lsu_req_wen   = wen;
        lsu_req_addr  = addr;
        lsu_req_wdata = wdata;
        lsu_req_wmask = wmask;
    endtask

    task automatic drive_idle();
        ifu_req_valid  = 1'b0;
        ifu_req_addr   = '0;
        ifu_resp_ready = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_req_wen    = 1'b0;
        lsu_req_addr   = '0;
        lsu_req_wdata  = '0;
        lsu_req_wmask  = '0;
        lsu_resp_ready = 1'b0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic model_clear();
        ifu_want   = 1'b0;
        lsu_want   = 1'b0;
        busy       = 1'b0;
        owner      = GNT_IFU;
        last_model = GNT_IFU;
        mreq_done  = 1'b0;
        mresp_done = 1'b0;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        ready_hold = urand(stall_lo, stall_hi);
        rr_hold    = urand(rrh_lo, rrh_hi);
        glog.delete();
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_ifu_req_ready"},  64'(ifu_req_ready),  64'd0);
        check({pfx, "_lsu_req_ready"},  64'(lsu_req_ready),  64'd0);
        check({pfx, "_ifu_resp_valid"}, 64'(ifu_resp_valid), 64'd0);
        check({pfx, "_lsu_resp_valid"}, 64'(lsu_resp_valid), 64'd0);
        check({pfx, "_mem_req_valid"},  64'(mem_req_valid),  64'd0);
        check({pfx, "_mem_resp_ready"}, 64'(mem_resp_ready), 64'd0);
        check({pfx, "_mem_req_wen"},    64'(mem_req_wen),    64'd0);
        check({pfx, "_mem_req_addr"},   64'(mem_req_addr),   64'd0);
        check({pfx, "_mem_req_wdata"},  64'(mem_req_wdata),  64'd0);
        check({pfx, "_mem_req_wmask"},  64'(mem_req_wmask),  64'd0);
        check({pfx, "_ifu_resp_rdata"}, 64'(ifu_resp_rdata), 64'd0);
        check({pfx, "_lsu_resp_rdata"}, 64'(lsu_resp_rdata), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive_idle();
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive at negedge, compare 1ns later, then advance the model to the next edge.
    task automatic step();
        bit ifu_acc, lsu_acc, mreq_hs, mresp_hs, iresp_hs, lresp_hs;
        bit exp_irdy, exp_lrdy, in_issue, in_resp;
        @(negedge clk);
        cyc++;
        if (!ifu_want && !(busy && owner == GNT_IFU) && urand(0, 99) < ifu_rate)
            post_ifu(rand_addr());
        if (!lsu_want && !(busy && owner == GNT_LSU) && urand(0, 99) < lsu_rate)
            post_lsu(1'($urandom_range(1)), rand_addr(), $urandom, 8'($urandom));
        ifu_req_valid  = ifu_want;
        lsu_req_valid  = lsu_want;
        mem_req_ready  = !mem_busy && (ready_hold == 0);
        mem_resp_valid = mem_busy && (mem_cnt == 0);
        mem_resp_rdata = !mem_busy ? 32'h0 : (mreq_wen ? $urandom : mem_arr[mreq_addr[5:2]]);
        ifu_resp_ready = (rr_hold == 0);
        lsu_resp_ready = (rr_hold == 0);
        #1;

        exp_irdy = !busy && ifu_want && (!lsu_want || last_model == GNT_LSU);
        exp_lrdy = !busy && lsu_want && (!ifu_want || last_model == GNT_IFU);
        in_issue = busy && !mreq_done;
        in_resp  = busy && mresp_done;
        check("ifu_req_ready", 64'(ifu_req_ready), 64'(exp_irdy));
        check("lsu_req_ready", 64'(lsu_req_ready), 64'(exp_lrdy));
        check("mem_req_valid", 64'(mem_req_valid), 64'(in_issue));
        if (in_issue) begin
            check("mem_req_wen",   64'(mem_req_wen),   64'(txn_wen));
            check("mem_req_addr",  64'(mem_req_addr),  64'(txn_addr));
            check("mem_req_wmask", 64'(mem_req_wmask), 64'(txn_wmask));
            if (txn_wen) check("mem_req_wdata", 64'(mem_req_wdata), 64'(txn_wdata));
        end
        check("mem_resp_ready", 64'(mem_resp_ready), 64'(busy && mreq_done && !mresp_done));
        check("ifu_resp_valid", 64'(ifu_resp_valid), 64'(in_resp && owner == GNT_IFU));
        check("lsu_resp_valid", 64'(lsu_resp_valid), 64'(in_resp && owner == GNT_LSU));
        if (in_resp && owner == GNT_IFU) check("ifu_resp_rdata", 64'(ifu_resp_rdata), 64'(exp_rdata));
        if (in_resp && owner == GNT_LSU) check("lsu_resp_rdata", 64'(lsu_resp_rdata), 64'(exp_rdata));
        if ((ifu_resp_valid || lsu_resp_valid) && !lat_seen) begin
            last_latency = cyc - accept_cyc;
            lat_seen     = 1'b1;
        end
        if (ifu_resp_valid || lsu_resp_valid) n_resp_vld++;

        ifu_acc  = ifu_req_valid && ifu_req_ready;
        lsu_acc  = lsu_req_valid && lsu_req_ready;
        mreq_hs  = mem_req_valid && mem_req_ready;
        mresp_hs = mem_resp_valid && mem_resp_ready;
        iresp_hs = ifu_resp_valid && ifu_resp_ready;
        lresp_hs = lsu_resp_valid && lsu_resp_ready;

        if (iresp_hs || lresp_hs) begin
            if (iresp_hs) last_ifu_rdata = ifu_resp_rdata;
            if (lresp_hs) last_lsu_rdata = lsu_resp_rdata;
            busy = 1'b0;
            n_resp_hs++;
            rr_hold = urand(rrh_lo, rrh_hi);
        end else if ((ifu_resp_valid || lsu_resp_valid) && rr_hold > 0) begin
            rr_hold--;
        end

        if (mresp_hs) begin
            mresp_done = 1'b1;
            n_mem_resp++;
            if (mreq_wen) begin
                for (int b = 0; b < 4; b++)
                    if (mreq_wmask[b]) mem_arr[mreq_addr[5:2]][8*b +: 8] = mreq_wdata[8*b +: 8];
            end
            mem_busy   = 1'b0;
            ready_hold = urand(stall_lo, stall_hi);
        end else if (mem_busy && mem_cnt > 0) begin
            mem_cnt--;
        end

        if (mreq_hs) begin
            mreq_done  = 1'b1;
            mem_busy   = 1'b1;
            mem_cnt    = urand(delay_lo, delay_hi);
            mreq_wen   = mem_req_wen;
            mreq_addr  = mem_req_addr;
            mreq_wdata = mem_req_wdata;
            mreq_wmask = mem_req_wmask;
        end else if (!mem_busy && mem_req_valid && ready_hold > 0) begin
            ready_hold--;
        end

        if (ifu_acc || lsu_acc) begin
            owner      = lsu_acc;
            busy       = 1'b1;
            mreq_done  = 1'b0;
            mresp_done = 1'b0;
            last_model = owner;
            glog.push_back(owner);
            accept_cyc = cyc;
            lat_seen   = 1'b0;
            if (lsu_acc) begin
                txn_wen   = lsu_req_wen;
                txn_addr  = lsu_req_addr;
                txn_wdata = lsu_req_wdata;
                txn_wmask = lsu_req_wen ? lsu_req_wmask : 8'h00;
                lsu_want  = 1'b0;
            end else begin
                txn_wen   = 1'b0;
                txn_addr  = ifu_req_addr;
                txn_wdata = 32'h0;
                txn_wmask = 8'h00;
                ifu_want  = 1'b0;
            end
            exp_rdata = txn_wen ? 32'h0 : mem_arr[txn_addr[5:2]];
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int n = 0;
        do begin
            step();
            n++;
        end while ((busy || ifu_want || lsu_want) && n < max);
        check({tag, "_idle_in_budget"}, 64'(busy || ifu_want || lsu_want), 64'd0);
    endtask

    task automatic set_knobs(input int ir, input int lr, input int sl, input int sh,
                             input int dl, input int dh, input int rl, input int rh);
        ifu_rate = ir; lsu_rate = lr;
        stall_lo = sl; stall_hi = sh;
        delay_lo = dl; delay_hi = dh;
        rrh_lo   = rl; rrh_hi   = rh;
        ready_hold = urand(sl, sh);
        rr_hold    = urand(rl, rh);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 16; i++) mem_arr[i] = $urandom;
        cyc = 0; n_mem_resp = 0; n_resp_hs = 0; n_resp_vld = 0;
        last_latency = 0; accept_cyc = 0; lat_seen = 1'b0;
        mreq_wen = 1'b0; mreq_addr = '0; mreq_wdata = '0; mreq_wmask = '0;
        txn_wen = 1'b0; txn_addr = '0; txn_wdata = '0; txn_wmask = '0; exp_rdata = '0;
        last_ifu_rdata = '0; last_lsu_rdata = '0;
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
        drive_idle();
        model_clear();

        // Reset state, with requests raised while reset is held.
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // IFU-only fetch with a zero-wait MEM.
        mem_arr[0] = 32'h0000_0413;
        post_ifu(32'h8000_0000);
        run_idle("fetch", 20);
        check("fetch_latency", 64'(last_latency), 64'd3);
        check("fetch_word", 64'(last_ifu_rdata), 64'h0000_0413);

        // LSU store, readback, and a zero-mask store that must leave memory untouched.
        post_lsu(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 8'h0F);
        run_idle("store", 20);
        check("store_mem_wen",   64'(mreq_wen),   64'd1);
        check("store_mem_addr",  64'(mreq_addr),  64'h8000_0004);
        check("store_mem_wdata", 64'(mreq_wdata), 64'hDEAD_BEEF);
        check("store_mem_wmask", 64'(mreq_wmask), 64'h0F);
        check("store_rdata",     64'(last_lsu_rdata), 64'd0);
        check("store_latency",   64'(last_latency),   64'd3);
        post_lsu(1'b1, 32'h8000_0004, 32'h1234_5678, 8'h00);
        run_idle("store_nomask", 20);
        check("nomask_mem_wmask", 64'(mreq_wmask), 64'd0);
        post_lsu(1'b0, 32'h8000_0004, 32'hFFFF_FFFF, 8'hFF);
        run_idle("load", 20);
        check("load_rdata", 64'(last_lsu_rdata), 64'hDEAD_BEEF);

        // Contention from reset: LSU first, then strict alternation over further pairs.
        do_reset();
        for (int p = 0; p < 5; p++) begin
            post_ifu(rand_addr());
            post_lsu(1'($urandom_range(1)), rand_addr(), $urandom, 8'($urandom));
            run_idle("pair", 40);
        end
        check("pair_grants", 64'(glog.size()), 64'd10);
        for (int g = 0; g < glog.size(); g++)
            check($sformatf("pair_grant_%0d", g), 64'(glog[g]), (g % 2 == 0) ? 64'(GNT_LSU) : 64'(GNT_IFU));

        // MEM stalls: ready low for 5 cycles, response 3 cycles after acceptance.
        set_knobs(0, 0, 5, 5, 3, 3, 0, 0);
        n_mem_resp = 0; n_resp_hs = 0;
        post_ifu(rand_addr());
        run_idle("stall", 40);
        check("stall_latency", 64'(last_latency), 64'd11);
        check("stall_mem_resps", 64'(n_mem_resp), 64'd1);
        check("stall_resps", 64'(n_resp_hs), 64'd1);

        // Requester holds resp_ready low 4 cycles; the other requester waits meanwhile.
        set_knobs(0, 0, 0, 0, 0, 0, 4, 4);
        n_resp_hs = 0; n_resp_vld = 0;
        post_ifu(rand_addr());
        post_lsu(1'b0, rand_addr(), 32'h0, 8'h00);
        run_idle("rhold", 60);
        check("rhold_resps", 64'(n_resp_hs), 64'd2);
        check("rhold_valid_cycles", 64'(n_resp_vld), 64'd10);

        // Reset pulse while waiting on MEM, then a stale MEM response, then a fresh fetch.
        set_knobs(0, 0, 0, 0, 10, 10, 0, 0);
        post_ifu(rand_addr());
        n = 0;
        do begin
            step();
            n++;
        end while (!mreq_done && n < 20);
        check("reached_wait", 64'(mreq_done), 64'd1);
        @(negedge clk);
        #1;
        check("in_wait_before_reset", 64'(mem_resp_ready), 64'd1);
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        drive_idle();
        set_knobs(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mreq_wen = 1'b0;
        mreq_addr = 32'h8000_0000;
        repeat (3) step();
        mem_busy = 1'b0;
        mem_arr[3] = 32'hCAFE_F00D;
        post_ifu(32'h8000_000C);
        run_idle("after_reset", 20);
        check("after_reset_word", 64'(last_ifu_rdata), 64'hCAFE_F00D);
        check("after_reset_latency", 64'(last_latency), 64'd3);

        // Randomised traffic on both requesters with random MEM and response stalls.
        set_knobs(35, 35, 0, 3, 0, 3, 0, 2);
        repeat (1500) step();
        ifu_rate = 0;
        lsu_rate = 0;
        run_idle("random_drain", 200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
